alu_iter_div: RTL and testbench
===============================

Name: alu_iter_div

Overview:
- Multi-cycle 32-bit restoring divider for DIV/DIVU, sitting in the execute stage beside the ALU.
- Acts as the initiator of the ALU interface: it drives a, b and aluc into the shared combinational ALU. It consumes r and carry.
- Each cycle, a SUBU trial subtraction is run on the ALU and the carry (borrow) flag selects the quotient bit.
- Results go to the HI/LO write path. The pipeline controller stalls on busy.

Parameters:
- ALUC_SUBU, 4'b0001, aluc code driven to the ALU for the trial subtraction. SUBU sets carry=1 when a<b (unsigned).
- DIV_ITER, 32, number of iteration cycles; equals the operand width, fixed at 32.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1=DIV (two's complement), 0=DIVU; captured at start.
- dividend  in  32  captured at start.
- divisor  in  32  captured at start.
- alu_a  out  32  trial minuend to ALU a.
- alu_b  out  32  divisor magnitude to ALU b.
- alu_aluc  out  4  constant ALUC_SUBU.
- alu_r  in  32  ALU difference.
- alu_carry  in  1  ALU borrow (1 = alu_a < alu_b).
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle registered pulse; results valid from this cycle.
- quotient  out  32  to LO.
- remainder  out  32  to HI.
- div_zero  out  1  divisor was 0 on the last operation.

Behaviour:
- Reset (rst_n=0 at an edge, including mid-operation):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_zero=0.
  - Iteration counter and internal registers are cleared.
- States: IDLE, CALC, FIX.
  - IDLE->CALC on start with divisor!=0.
  - IDLE->FIX on start with divisor==0.
  - CALC->FIX when iteration count reaches DIV_ITER.
  - FIX->IDLE always.
- Start capture, counting the start-sampling edge as edge 0:
  - dvd = |dividend| and dsr = |divisor| when is_signed, else the raw values.
  - Latch q_neg = dividend[31]^divisor[31] and r_neg = dividend[31]; both are forced to 0 when unsigned.
  - rem is cleared.
  - |0x80000000| = 0x80000000, taken as an unsigned magnitude.
- CALC, edges 1..32:
  - alu_a = {rem[30:0], dvd[31]} and alu_b = dsr, both combinational from registers.
  - If alu_carry=0: rem <= alu_r and qbit = 1.
  - If alu_carry=1: rem <= alu_a and qbit = 0.
  - dvd <= {dvd[30:0], qbit}, so the quotient accumulates in dvd.
  - Invariant: before iteration k, rem < 2^(k-1), so a 32-bit rem never overflows. No 33rd bit is needed.
- FIX, edge 33 (normal case):
  - quotient <= q_neg ? -dvd : dvd.
  - remainder <= r_neg ? -rem : rem.
  - done <= 1, div_zero <= 0.
  - busy falls at the same edge.
- FIX, edge 1 (divide-by-zero case):
  - quotient <= 32'hFFFFFFFF, remainder <= dividend as captured (signed-ness ignored).
  - div_zero <= 1, done <= 1.
- Outputs hold their values until the next completion or reset. done returns to 0 after one cycle.
- start while busy=1 is ignored, with no queuing. A start in the done cycle (state IDLE) is accepted.
- alu_aluc is always ALUC_SUBU. alu_a and alu_b are don't-care outside CALC but must be driven from registers, with no latches.
- Signed overflow: 0x80000000 / -1 gives quotient=0x80000000, remainder=0. No exception is raised.

Decomposition:
- Package div_pkg holds:
  - ALUC_SUBU and DIV_ITER constants.
  - State encoding localparams (IDLE=2'd0, CALC=2'd1, FIX=2'd2).
  - Functions abs32 and neg32 for the sign fix-up.
- No sub-module. The ALU is instantiated by the parent execute stage and wired to the alu_* ports, keeping the arithmetic in one place.

Test Plan:
- Unsigned 100/7: start with is_signed=0, dividend=100, divisor=7 -> done at edge 33; quotient=14, remainder=2, div_zero=0. busy high from edge 0 to edge 33.
- Signed -7/2: dividend=0xFFFFFFF9, divisor=2, is_signed=1 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Then 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
- Max borrow path: unsigned 0xFFFFFFFF/0x80000001 -> quotient=1, remainder=0x7FFFFFFE. Also check alu_aluc=4'b0001 in every CALC cycle.
- Divide by zero: 5/0 -> done at edge 1; quotient=0xFFFFFFFF, remainder=5, div_zero=1. A following 9/3 -> quotient=3, remainder=0, div_zero=0.
- Signed overflow: 0x80000000 / 0xFFFFFFFF with is_signed=1 -> quotient=0x80000000, remainder=0 at edge 33.
- Control corners:
  - start pulsed at edge 5 of a running op -> ignored; the original result is unchanged at edge 33.
  - rst_n=0 at edge 10 -> next cycle busy=0, done=0, quotient=0, remainder=0; no done pulse follows.
  - Back-to-back start in the done cycle -> accepted; second done at 33 edges later.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants, state encoding and sign helpers
// for the iterative DIV/DIVU unit in the execute stage.
package div_pkg;

    localparam logic [3:0] ALUC_SUBU = 4'b0001;
    localparam int         DIV_ITER  = 32;
    localparam int         CNT_W     = $clog2(DIV_ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Two's complement negate.
    function automatic logic [31:0] neg32(input logic [31:0] a);
        return ~a + 32'd1;
    endfunction

    // Magnitude; 0x80000000 maps to itself as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] a);
        return a[31] ? neg32(a) : a;
    endfunction

endpackage

// File: rtl/alu_iter_div.sv
// Restoring 32-bit divider; one trial SUBU per cycle
// on the shared ALU, sign fix-up in a final cycle.
module alu_iter_div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_r,
    input  logic        alu_carry,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      dvd;
    logic [31:0]      dsr;
    logic [31:0]      rem;
    logic             q_neg;
    logic             r_neg;
    logic             dz;
    logic             qbit;
    logic [31:0]      rem_nx;

    assign alu_a    = {rem[30:0], dvd[31]};
    assign alu_b    = dsr;
    assign alu_aluc = ALUC_SUBU;

    // Borrow from the trial subtraction restores the minuend.
    always_comb begin
        qbit   = ~alu_carry;
        rem_nx = alu_carry ? alu_a : alu_r;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd       <= '0;
            dsr       <= '0;
            rem       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            dz        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        cnt   <= '0;
                        rem   <= '0;
                        q_neg <= is_signed
                               & (dividend[31] ^ divisor[31]);
                        r_neg <= is_signed & dividend[31];
                        if (divisor == 32'd0) begin
                            dvd   <= dividend;
                            dsr   <= '0;
                            dz    <= 1'b1;
                            state <= FIX;
                        end else begin
                            dvd   <= is_signed ? abs32(dividend)
                                               : dividend;
                            dsr   <= is_signed ? abs32(divisor)
                                               : divisor;
                            dz    <= 1'b0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    dvd <= {dvd[30:0], qbit};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DIV_ITER - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz) begin
                        quotient  <= 32'hFFFF_FFFF;
                        remainder <= dvd;
                        div_zero  <= 1'b1;
                    end else begin
                        quotient  <= q_neg ? neg32(dvd) : dvd;
                        remainder <= r_neg ? neg32(rem) : rem;
                        div_zero  <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter_div.sv
// Directed bench for alu_iter_div with a behavioural
// SUBU ALU standing in for the shared execute-stage ALU.
module tb_alu_iter_div;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_aluc;
    logic [31:0] alu_r;
    logic        alu_carry;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int total;
    int bad;

    alu_iter_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_aluc  (alu_aluc),
        .alu_r     (alu_r),
        .alu_carry (alu_carry),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // SUBU: difference and unsigned borrow.
    assign alu_r     = alu_a - alu_b;
    assign alu_carry = (alu_a < alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request and consume edge 0; returns at edge0+#1.
    task automatic start_op(input logic sgn,
                            input logic [31:0] a,
                            input logic [31:0] b);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges until done is seen (-1 on timeout).
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        is_signed = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++;
        if ({busy, done, div_zero} !== 3'b000
            || quotient !== 32'd0 || remainder !== 32'd0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b dz=%b q=%h r=%h want all 0",
                     busy, done, div_zero, quotient, remainder);
        end
    endtask

    task automatic test_unsigned();
        logic ok;
        start_op(1'b0, 32'd100, 32'd7);
        ok = busy && !done;
        for (int i = 1; i < 33; i++) begin
            @(posedge clk);
            #1;
            if (!busy || done) ok = 1'b0;
        end
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL udiv_busy: busy/done wrong in edges 0..32, got ok=%b want 1", ok);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL udiv_edge33: done=%b busy=%b want 1 0", done, busy);
        end
        total++;
        if (quotient !== 32'd14 || remainder !== 32'd2
            || div_zero !== 1'b0) begin
            bad++;
            $display("FAIL udiv_100_7: q=%h r=%h dz=%b want 0000000e 00000002 0",
                     quotient, remainder, div_zero);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || quotient !== 32'd14) begin
            bad++;
            $display("FAIL done_pulse: done=%b q=%h want 0 0000000e", done, quotient);
        end
    endtask

    task automatic test_signed();
        int n;
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        total++;
        if (n !== 33 || quotient !== 32'hFFFF_FFFD
            || remainder !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL sdiv_m7_2: lat=%0d q=%h r=%h want 33 fffffffd ffffffff",
                     n, quotient, remainder);
        end
        start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(n);
        total++;
        if (n !== 33 || quotient !== 32'hFFFF_FFFD
            || remainder !== 32'd1) begin
            bad++;
            $display("FAIL sdiv_7_m2: lat=%0d q=%h r=%h want 33 fffffffd 00000001",
                     n, quotient, remainder);
        end
    endtask

    task automatic test_max_borrow();
        logic aluc_ok;
        logic b_ok;
        int   calc;
        int   n;
        aluc_ok = 1'b1;
        b_ok = 1'b1;
        calc = 0;
        n = -1;
        start_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001);
        for (int i = 1; i <= 40; i++) begin
            if (busy && calc < 32) begin
                calc++;
                if (alu_aluc !== 4'b0001) aluc_ok = 1'b0;
                if (alu_b !== 32'h8000_0001) b_ok = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
        total++;
        if (aluc_ok !== 1'b1 || calc != 32) begin
            bad++;
            $display("FAIL aluc_calc: ok=%b cycles=%0d want 1 32", aluc_ok, calc);
        end
        total++;
        if (b_ok !== 1'b1) begin
            bad++;
            $display("FAIL alu_b_calc: ok=%b want 1", b_ok);
        end
        total++;
        if (n !== 33 || quotient !== 32'd1
            || remainder !== 32'h7FFF_FFFE) begin
            bad++;
            $display("FAIL udiv_max: lat=%0d q=%h r=%h want 33 00000001 7ffffffe",
                     n, quotient, remainder);
        end
    endtask

    task automatic test_div_zero();
        int n;
        start_op(1'b1, 32'd5, 32'd0);
        wait_done(n);
        total++;
        if (n !== 1 || quotient !== 32'hFFFF_FFFF
            || remainder !== 32'd5 || div_zero !== 1'b1) begin
            bad++;
            $display("FAIL div_zero: lat=%0d q=%h r=%h dz=%b want 1 ffffffff 00000005 1",
                     n, quotient, remainder, div_zero);
        end
        @(posedge clk);
        #1;
        start_op(1'b0, 32'd9, 32'd3);
        wait_done(n);
        total++;
        if (n !== 33 || quotient !== 32'd3
            || remainder !== 32'd0 || div_zero !== 1'b0) begin
            bad++;
            $display("FAIL after_zero: lat=%0d q=%h r=%h dz=%b want 33 3 0 0",
                     n, quotient, remainder, div_zero);
        end
    endtask

    task automatic test_overflow();
        int n;
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        total++;
        if (n !== 33 || quotient !== 32'h8000_0000
            || remainder !== 32'd0) begin
            bad++;
            $display("FAIL s_overflow: lat=%0d q=%h r=%h want 33 80000000 0",
                     n, quotient, remainder);
        end
    endtask

    task automatic test_start_ignored();
        int n;
        start_op(1'b0, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        is_signed = 1'b1;
        dividend = 32'd50;
        divisor = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        total++;
        if (n !== 28 || quotient !== 32'd14
            || remainder !== 32'd2) begin
            bad++;
            $display("FAIL start_busy: lat=%0d q=%h r=%h want 28 0000000e 00000002",
                     n, quotient, remainder);
        end
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL no_queue: busy=%b want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        logic seen;
        start_op(1'b0, 32'd1000, 32'd10);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++;
        if ({busy, done, div_zero} !== 3'b000
            || quotient !== 32'd0 || remainder !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b done=%b q=%h r=%h want 0 0 0 0",
                     busy, done, quotient, remainder);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_done: activity=%b want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start_op(1'b0, 32'd50, 32'd6);
        wait_done(n);
        total++;
        if (n !== 33 || quotient !== 32'd8 || remainder !== 32'd2) begin
            bad++;
            $display("FAIL b2b_first: lat=%0d q=%h r=%h want 33 8 2",
                     n, quotient, remainder);
        end
        start_op(1'b1, 32'hFFFF_FF9C, 32'd9);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: busy=%b want 1", busy);
        end
        wait_done(n);
        total++;
        if (n !== 33 || quotient !== 32'hFFFF_FFF5
            || remainder !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL b2b_second: lat=%0d q=%h r=%h want 33 fffffff5 ffffffff",
                     n, quotient, remainder);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_max_borrow();
        test_div_zero();
        test_overflow();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
